// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target with memory-mapped status/data word
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] in,
  input  logic        clear,
  output logic [15:0] out,
  input  logic        SCK,
  input  logic        CSX,
  input  logic        SDI,
  output logic        SDO,
  output logic        SDO_OE
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, csx_sync, sdi_sync;
  logic [SYNC_STAGES-1:0] sync_valid;
  logic                   sck_s, csx_s, sdi_s;

  logic       sck_d, csx_d, armed;
  logic       sck_rise_p, sck_fall_p, csx_fall_p, csx_rise_p, sdi_p;

  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       rx_bit;
  logic       sdo_q;
  logic [7:0] tx_hold;
  logic       tx_pending;
  logic [7:0] rx_byte;
  logic       no_data;
  logic       overrun;

  logic       frame_start;
  logic       frame_abort;
  logic       byte_done;
  logic [7:0] reload_value;
  logic       unused_in_hi;

  assign unused_in_hi = ^in[15:8];

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign csx_s = csx_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  // Pin synchronizers; sync_valid marks when the chain holds real pin samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync   <= '0;
      csx_sync   <= '1;
      sdi_sync   <= '0;
      sync_valid <= '0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], SCK};
      csx_sync   <= {csx_sync[SYNC_STAGES-2:0], CSX};
      sdi_sync   <= {sdi_sync[SYNC_STAGES-2:0], SDI};
      sync_valid <= {sync_valid[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Registered edge pulses; a frame may only start after CSX was seen high post-reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_d      <= 1'b0;
      csx_d      <= 1'b1;
      armed      <= 1'b0;
      sck_rise_p <= 1'b0;
      sck_fall_p <= 1'b0;
      csx_fall_p <= 1'b0;
      csx_rise_p <= 1'b0;
      sdi_p      <= 1'b0;
    end else begin
      sck_d      <= sck_s;
      csx_d      <= csx_s;
      armed      <= armed | (sync_valid[SYNC_STAGES-1] & csx_s);
      sck_rise_p <= sck_s & ~sck_d;
      sck_fall_p <= ~sck_s & sck_d;
      csx_fall_p <= armed & csx_d & ~csx_s;
      csx_rise_p <= csx_s & ~csx_d;
      sdi_p      <= sdi_s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and pad outputs; SDO idles high whenever the pad is not driven
  always_comb begin
    state_next = state;
    SDO_OE     = 1'b0;
    SDO        = 1'b1;
    case (state)
      IDLE: begin
        if (csx_fall_p) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        SDO_OE = 1'b1;
        SDO    = sdo_q;
        if (csx_rise_p) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign frame_start  = (state == IDLE) && csx_fall_p;
  assign frame_abort  = (state == ACTIVE) && csx_rise_p;
  assign byte_done    = (state == ACTIVE) && !csx_rise_p && sck_rise_p && (bit_cnt == 3'd7);
  assign reload_value = tx_pending ? tx_hold : 8'hFF;

  // TX holding register; a load in the same cycle as a consumption stays pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_hold    <= 8'h00;
      tx_pending <= 1'b0;
    end else begin
      if (load) begin
        tx_hold    <= in[7:0];
        tx_pending <= 1'b1;
      end else if (frame_start || byte_done) begin
        tx_pending <= 1'b0;
      end
    end
  end

  // Shift register and bit counter: sample SDI on rise, shift it in and advance SDO on fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      shift   <= 8'hFF;
      rx_bit  <= 1'b0;
      sdo_q   <= 1'b1;
    end else if (frame_start) begin
      bit_cnt <= 3'd0;
      shift   <= reload_value;
      sdo_q   <= reload_value[7];
    end else if (frame_abort) begin
      bit_cnt <= 3'd0;
    end else if (state == ACTIVE) begin
      if (sck_rise_p) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_bit  <= sdi_p;
        if (bit_cnt == 3'd7) begin
          shift <= reload_value;
        end
      end else if (sck_fall_p) begin
        if (bit_cnt != 3'd0) begin
          shift <= {shift[6:0], rx_bit};
          sdo_q <= shift[6];
        end else begin
          sdo_q <= shift[7];
        end
      end
    end
  end

  // RX byte and status flags; byte completion takes priority over clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_byte <= 8'h00;
      no_data <= 1'b1;
      overrun <= 1'b0;
    end else if (byte_done) begin
      rx_byte <= {shift[6:0], sdi_p};
      no_data <= 1'b0;
      overrun <= clear ? 1'b0 : (overrun | ~no_data);
    end else if (clear) begin
      no_data <= 1'b1;
      overrun <= 1'b0;
    end
  end

  assign out = {no_data, overrun, tx_pending, 5'b00000, rx_byte};

endmodule
